frame_sync_ctrl: RTL and testbench
==================================

Name: frame_sync_ctrl

Overview:
Sequences the SNES-to-HDMI frame-lock handshake in the SNES clock domain. Once per N SNES frames it halts the core during DRAM refresh on a chosen line, waits for the HDMI pixel pipeline to signal frame start, then releases the core. It also provides a timeout watchdog and lock and drift status for the OSD and debug. It drives the core's pause input and sits between the SNES core and the SNES-to-HDMI line-buffer converter.

Parameters:
SYNC_LINE, 2, SNES line (ys[7:0]) on which the pause is taken
REARM_LINE, 200, SNES line at which the next sync is armed
TIMEOUT, 24'd2000000, max pause length in clk cycles before forced release
SYNC_EVERY, 1, sync once every SYNC_EVERY frames (1..15)

Ports:
clk  in  1  SNES clock
resetn  in  1  asynchronous active-low reset
enable  in  1  frame sync enabled (from OSD config)
ys  in  8  current SNES line
snes_refresh  in  1  core is in DRAM refresh window
hdmi_frame_tog  in  1  toggles once per HDMI frame at first active line; from clk_pixel domain, asynchronous
pause_snes_for_frame_sync  out  1  halt request to SNES core
sync_state  out  2  0=IDLE 1=ARMED 2=PAUSED 3=DONE
locked  out  1  last sync completed by HDMI edge, not timeout
last_wait  out  24  clk cycles spent paused in last completed sync, saturating
timeout_count  out  8  number of forced releases, saturating at 255

Behaviour:
- Reset: all outputs 0, state IDLE, frame counter 0, synchronizer flops 0.
- CDC: hdmi_frame_tog passes through a 2-flop synchronizer (s1, s2) plus a history flop s3. hdmi_edge = s2 ^ s3. A toggle that is stable before clk edge k yields hdmi_edge high during cycle k+2. Edges are never latched. An edge arriving outside PAUSED is discarded.
- IDLE: pause=0. Move to ARMED when enable=1.
- ARMED: when ys==SYNC_LINE and snes_refresh=1:
  - if frame counter == SYNC_EVERY-1: counter<=0, go PAUSED, pause<=1 (registered, high one cycle after the qualifying cycle), wait counter<=0.
  - else: counter++, go DONE without pausing.
- PAUSED: pause=1. Wait counter increments each cycle, saturating at 24'hFFFFFF.
  - On hdmi_edge: pause<=0, last_wait<=wait counter, locked<=1, go DONE.
  - Else when wait counter == TIMEOUT-1: pause<=0, last_wait<=TIMEOUT, locked<=0, timeout_count++ (saturating), go DONE.
  - hdmi_edge and timeout in the same cycle: treat as edge (locked=1, no timeout count).
- DONE: pause=0. Move to ARMED when ys==REARM_LINE. If SYNC_LINE is seen again before REARM_LINE, no action.
- enable falling in any state: next cycle pause=0, locked=0, state IDLE, frame counter 0. last_wait and timeout_count are held. Enable rising again re-enters ARMED.
- Reset asserted mid-pause: pause drops asynchronously and immediately.
- pause is a pure register output and never glitches.
- ys is sampled as-is: it is in the clk domain and the core holds it stable while paused.

Test Plan:
- Basic lock: enable=1, drive ys=2 with snes_refresh=1 for 1 cycle, toggle hdmi_frame_tog 100 cycles later -> pause high from cycle 1 to cycle 102 inclusive (±0), last_wait=101, locked=1, state DONE.
- Timeout: TIMEOUT=1000, pause entered, no toggle -> pause falls after exactly 1000 cycles, last_wait=1000, timeout_count=1, locked=0. Next toggle while DONE is ignored.
- Stray edge: toggle hdmi_frame_tog while ARMED, then enter PAUSED -> no immediate release; release only on a subsequent toggle.
- Skip frames: SYNC_EVERY=3, run 6 frames (ys sweeps 0..261) -> pause occurs on frames 3 and 6 only.
- Disable mid-pause: enable=0 at cycle 50 of pause -> pause=0 at cycle 51, state IDLE, last_wait unchanged. Async reset mid-pause -> pause 0 with no clk edge.
- Rearm boundary: ys jumps from 2 to 199 and back to 2 without hitting 200 -> no second pause. Hitting 200 then 2 -> pause.

Source files
------------

// File: rtl/frame_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_sync_ctrl
// Brief    : Halts the SNES core on a chosen DRAM-refresh line until the HDMI
//            pipeline reports frame start, with a timeout watchdog and status.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sync_ctrl #(
    parameter logic [7:0]  SYNC_LINE  = 8'd2,
    parameter logic [7:0]  REARM_LINE = 8'd200,
    parameter logic [23:0] TIMEOUT    = 24'd2000000,
    parameter int unsigned SYNC_EVERY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [7:0]  ys,
    input  logic        snes_refresh,
    input  logic        hdmi_frame_tog,
    output logic        pause_snes_for_frame_sync,
    output logic [1:0]  sync_state,
    output logic        locked,
    output logic [23:0] last_wait,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  FRAME_LAST = 4'(SYNC_EVERY - 1);
    localparam logic [23:0] WAIT_LAST  = TIMEOUT - 24'd1;
    localparam logic [23:0] WAIT_MAX   = 24'hFFFFFF;
    localparam logic [7:0]  TCOUNT_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // HDMI frame toggle: two-flop synchronizer plus one history flop
    // ------------------------------------------------------------------
    logic tog_s1_q;
    logic tog_s2_q;
    logic tog_s3_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tog_s1_q <= 1'b0;
            tog_s2_q <= 1'b0;
            tog_s3_q <= 1'b0;
        end else begin
            tog_s1_q <= hdmi_frame_tog;
            tog_s2_q <= tog_s1_q;
            tog_s3_q <= tog_s2_q;
        end
    end

    logic w_hdmi_edge;
    assign w_hdmi_edge = tog_s2_q ^ tog_s3_q;

    // ------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [23:0] wait_q,      wait_d;
    logic        pause_q,     pause_d;
    logic        locked_q,    locked_d;
    logic [23:0] last_wait_q, last_wait_d;
    logic [7:0]  tcount_q,    tcount_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= 4'd0;
            wait_q      <= 24'd0;
            pause_q     <= 1'b0;
            locked_q    <= 1'b0;
            last_wait_q <= 24'd0;
            tcount_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            wait_q      <= wait_d;
            pause_q     <= pause_d;
            locked_q    <= locked_d;
            last_wait_q <= last_wait_d;
            tcount_q    <= tcount_d;
        end
    end

    logic        w_sync_hit;
    logic        w_rearm_hit;
    logic        w_frame_due;
    logic        w_timeout;
    logic [23:0] w_wait_inc;
    logic [7:0]  w_tcount_inc;

    assign w_sync_hit   = (ys == SYNC_LINE) && snes_refresh;
    assign w_rearm_hit  = (ys == REARM_LINE);
    assign w_frame_due  = (frame_cnt_q == FRAME_LAST);
    assign w_timeout    = (wait_q == WAIT_LAST);
    assign w_wait_inc   = (wait_q == WAIT_MAX) ? wait_q : wait_q + 24'd1;
    assign w_tcount_inc = (tcount_q == TCOUNT_MAX) ? tcount_q : tcount_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        wait_d      = wait_q;
        pause_d     = pause_q;
        locked_d    = locked_q;
        last_wait_d = last_wait_q;
        tcount_d    = tcount_q;

        // Disable overrides everything; wait history and timeout tally survive.
        if (!enable) begin
            state_d     = ST_IDLE;
            pause_d     = 1'b0;
            locked_d    = 1'b0;
            frame_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    pause_d = 1'b0;
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    pause_d = 1'b0;
                    if (w_sync_hit) begin
                        if (w_frame_due) begin
                            frame_cnt_d = 4'd0;
                            wait_d      = 24'd0;
                            pause_d     = 1'b1;
                            state_d     = ST_PAUSED;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 4'd1;
                            state_d     = ST_DONE;
                        end
                    end
                end
                ST_PAUSED: begin
                    pause_d = 1'b1;
                    wait_d  = w_wait_inc;
                    // An HDMI edge wins over a coincident timeout.
                    if (w_hdmi_edge) begin
                        pause_d     = 1'b0;
                        last_wait_d = wait_q;
                        locked_d    = 1'b1;
                        state_d     = ST_DONE;
                    end else if (w_timeout) begin
                        pause_d     = 1'b0;
                        last_wait_d = TIMEOUT;
                        locked_d    = 1'b0;
                        tcount_d    = w_tcount_inc;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    pause_d = 1'b0;
                    if (w_rearm_hit) begin
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    pause_d = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign pause_snes_for_frame_sync = pause_q;
    assign sync_state                = state_q;
    assign locked                    = locked_q;
    assign last_wait                 = last_wait_q;
    assign timeout_count             = tcount_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_frame_sync_ctrl
// Brief    : Directed and randomized checks of frame_sync_ctrl against an
//            arithmetic model of pause length, lock and timeout status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sync_ctrl;

    localparam int T = 1000;

    logic       clk            = 1'b0;
    logic       resetn         = 1'b0;
    logic       enable         = 1'b0;
    logic [7:0] ys             = 8'd0;
    logic       snes_refresh   = 1'b0;
    logic       hdmi_frame_tog = 1'b0;

    logic        a_pause, b_pause;
    logic [1:0]  a_state, b_state;
    logic        a_locked, b_locked;
    logic [23:0] a_lw, b_lw;
    logic [7:0]  a_tc, b_tc;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_tc   = 0;
    int exp_lw   = 0;
    int exp_lock = 0;

    always #5 clk = ~clk;

    frame_sync_ctrl #(
        .SYNC_LINE(8'd2), .REARM_LINE(8'd200), .TIMEOUT(24'd1000), .SYNC_EVERY(1)
    ) dut_a (
        .clk(clk), .resetn(resetn), .enable(enable), .ys(ys),
        .snes_refresh(snes_refresh), .hdmi_frame_tog(hdmi_frame_tog),
        .pause_snes_for_frame_sync(a_pause), .sync_state(a_state),
        .locked(a_locked), .last_wait(a_lw), .timeout_count(a_tc)
    );

    frame_sync_ctrl #(
        .SYNC_LINE(8'd2), .REARM_LINE(8'd200), .TIMEOUT(24'd1000), .SYNC_EVERY(3)
    ) dut_b (
        .clk(clk), .resetn(resetn), .enable(enable), .ys(ys),
        .snes_refresh(snes_refresh), .hdmi_frame_tog(hdmi_frame_tog),
        .pause_snes_for_frame_sync(b_pause), .sync_state(b_state),
        .locked(b_locked), .last_wait(b_lw), .timeout_count(b_tc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rearm on line 200, optionally inject a stray HDMI edge while armed,
    // then qualify on line 2; returns in the first cycle after qualification.
    task automatic qualify(input bit stray);
        ys = 8'd200; snes_refresh = 1'b0;
        @(negedge clk);
        check("armed_before_sync", a_state, 1);
        if (stray) begin
            hdmi_frame_tog = ~hdmi_frame_tog;
            ys = 8'd10;
            repeat (5) @(negedge clk);
            check("stray_no_pause", a_pause, 0);
            check("stray_still_armed", a_state, 1);
        end
        ys = 8'd2; snes_refresh = 1'b1;
        @(negedge clk);
        ys = 8'd3; snes_refresh = 1'b0;
    endtask

    // One sync on dut_a; tog_at <= 0 means no HDMI toggle at all.
    task automatic episode(input int tog_at, input bit stray, input string tag);
        int  rel, limit, hi_first, hi_last, hi_cnt, edge_cyc;
        bit  lk;
        edge_cyc = tog_at + 2;
        lk       = (tog_at > 0) && (edge_cyc <= T);
        rel      = lk ? edge_cyc : T;
        limit    = ((tog_at > 0 && edge_cyc > T) ? edge_cyc : T) + 4;
        if (lk) begin
            exp_lw = tog_at + 1;
        end else begin
            exp_lw = T;
            if (exp_tc < 255) exp_tc++;
        end
        exp_lock = lk ? 1 : 0;

        qualify(stray);
        hi_first = 0; hi_last = 0; hi_cnt = 0;
        for (int c = 1; c <= limit; c++) begin
            if (a_pause === 1'b1) begin
                if (hi_first == 0) hi_first = c;
                hi_last = c;
                hi_cnt++;
            end
            if (c == tog_at) hdmi_frame_tog = ~hdmi_frame_tog;
            @(negedge clk);
        end
        check({tag, "_pause_first"}, hi_first, 1);
        check({tag, "_pause_last"},  hi_last,  rel);
        check({tag, "_pause_len"},   hi_cnt,   rel);
        check({tag, "_last_wait"},   a_lw,     exp_lw);
        check({tag, "_locked"},      a_locked, exp_lock);
        check({tag, "_tcount"},      a_tc,     exp_tc);
        check({tag, "_state_done"},  a_state,  3);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rel_ok;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pause",  a_pause,  0);
        check("rst_state",  a_state,  0);
        check("rst_locked", a_locked, 0);
        check("rst_lw",     a_lw,     0);
        check("rst_tc",     a_tc,     0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_no_enable", a_state, 0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("enable_armed", a_state, 1);

        // Directed syncs
        episode(100, 1'b0, "basic");
        episode(50,  1'b1, "stray");
        episode(0,   1'b0, "timeout");
        episode(T - 2, 1'b0, "tie");
        episode(T - 1, 1'b0, "late");
        for (int i = 0; i < 5; i++)
            episode(int'($urandom_range(1, 1100)), 1'b0, $sformatf("rand%0d", i));

        // Rearm boundary: line 199 is not the rearm line
        ys = 8'd2; snes_refresh = 1'b1; @(negedge clk);
        ys = 8'd199; snes_refresh = 1'b0; @(negedge clk);
        ys = 8'd2; snes_refresh = 1'b1; @(negedge clk);
        ys = 8'd3; snes_refresh = 1'b0;
        check("rearm_miss_pause", a_pause, 0);
        @(negedge clk);
        check("rearm_miss_pause2", a_pause, 0);
        check("rearm_miss_state", a_state, 3);
        episode(int'($urandom_range(5, 900)), 1'b0, "rearm_hit");

        // Disable at cycle 50 of a pause
        qualify(1'b0);
        repeat (49) @(negedge clk);
        check("dis_pause_c50", a_pause, 1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_pause_c51", a_pause,  0);
        check("dis_state",     a_state,  0);
        check("dis_locked",    a_locked, 0);
        check("dis_lw_held",   a_lw,     exp_lw);
        check("dis_tc_held",   a_tc,     exp_tc);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("reenable_armed", a_state, 1);

        // Asynchronous reset mid-pause, no clock edge in between
        qualify(1'b0);
        repeat (10) @(negedge clk);
        check("ar_pause_before", a_pause, 1);
        resetn = 1'b0;
        #1;
        check("ar_pause",  a_pause,  0);
        check("ar_state",  a_state,  0);
        check("ar_lw",     a_lw,     0);
        check("ar_tc",     a_tc,     0);
        check("ar_locked", a_locked, 0);
        @(negedge clk);
        resetn = 1'b1;
        ys = 8'd0;
        repeat (2) @(negedge clk);
        check("skip_armed", b_state, 1);

        // Skip frames on dut_b (SYNC_EVERY=3)
        for (int f = 1; f <= 6; f++) begin
            for (int y = 0; y < 262; y++) begin
                ys = 8'(y);
                snes_refresh = (y == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                if (y == 2) begin
                    snes_refresh = 1'b0;
                    check($sformatf("skip_f%0d_pause", f), b_pause, (f % 3 == 0) ? 1 : 0);
                    if (b_pause === 1'b1) begin
                        hdmi_frame_tog = ~hdmi_frame_tog;
                        rel_ok = 1'b0;
                        for (int k = 0; k < 10; k++) begin
                            @(negedge clk);
                            if (b_pause === 1'b0) begin
                                rel_ok = 1'b1;
                                break;
                            end
                        end
                        check($sformatf("skip_f%0d_release", f), rel_ok, 1);
                        check($sformatf("skip_f%0d_locked", f), b_locked, 1);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
